// File: rtl/jacobi_ram_arbiter.sv
// Round-robin arbiter sharing one Jacobi RAM port between N_REQ requesters, with burst lock.
// Latency: grant is combinational; RAM command 1 cycle after accept; read response RD_LATENCY+1 cycles after accept.
// Backpressure: a requester stalls while req_rdy_o is low (another winner or a lock held by another owner).
module jacobi_ram_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld_i,
  input  logic [N_REQ-1:0]          req_we_i,
  input  logic [N_REQ-1:0]          req_lock_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_din_i,
  output logic [N_REQ-1:0]          req_rdy_o,
  output logic [N_REQ-1:0]          rsp_vld_o,
  output logic [DATA_W-1:0]         rsp_dat_o,
  output logic                      ram_en_o,
  output logic                      ram_we_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic [DATA_W-1:0]         ram_din_o,
  input  logic [DATA_W-1:0]         ram_dout_i,
  output logic                      busy_o
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PIPE_D = RD_LATENCY + 1;

  // Arbitration state
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  lock_owner;
  logic              lock_active;

  // Combinational arbitration results
  logic              lock_hold;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  // Read-return tracking: stage k holds a read whose command went out k cycles ago
  logic [PIPE_D-1:0] pipe_vld;
  logic [N_REQ-1:0]  pipe_id [PIPE_D];

  // A lock only pins the grant while its owner keeps requesting; dropping vld frees the port immediately
  always_comb begin
    lock_hold = lock_active && req_vld_i[lock_owner];
  end

  // Pick the winner: locked owner, else first valid requester after rr_ptr (wrapping)
  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (!rst) begin
      if (lock_hold) begin
        grant[lock_owner] = 1'b1;
        grant_idx         = lock_owner;
      end else begin
        for (int k = 1; k <= N_REQ; k++) begin
          cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
          if (cand >= (IDX_W+1)'(N_REQ)) begin
            cand = cand - (IDX_W+1)'(N_REQ);
          end
          if (!found && req_vld_i[cand[IDX_W-1:0]]) begin
            found                     = 1'b1;
            grant[cand[IDX_W-1:0]]    = 1'b1;
            grant_idx                 = cand[IDX_W-1:0];
          end
        end
      end
    end
  end

  // Mux the winning requester's command fields
  always_comb begin
    accept   = |grant;
    sel_we   = req_we_i[grant_idx];
    sel_lock = req_lock_i[grant_idx];
    sel_addr = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_din  = req_din_i[int'(grant_idx)*DATA_W +: DATA_W];
  end

  assign req_rdy_o = grant;

  // Round-robin pointer and lock ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= IDX_W'(N_REQ-1);
      lock_owner  <= '0;
      lock_active <= 1'b0;
    end else if (accept) begin
      rr_ptr      <= grant_idx;
      lock_owner  <= grant_idx;
      lock_active <= sel_lock;
    end else begin
      // No accept while locked can only mean the owner dropped vld
      lock_active <= 1'b0;
    end
  end

  // Registered RAM command; address and data hold when idle to avoid needless toggling
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_din_o  <= '0;
    end else begin
      ram_en_o <= accept;
      ram_we_o <= accept & sel_we;
      if (accept) begin
        ram_addr_o <= sel_addr;
        ram_din_o  <= sel_din;
      end
    end
  end

  // Read-id pipeline: one slot per cycle so back-to-back reads never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < PIPE_D; k++) begin
        pipe_id[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= accept & ~sel_we;
      pipe_id[0]  <= grant;
      for (int k = 1; k < PIPE_D; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  // Response strobe lines up with the RAM data arriving RD_LATENCY cycles after the command
  always_comb begin
    rsp_vld_o = pipe_vld[RD_LATENCY] ? pipe_id[RD_LATENCY] : '0;
    rsp_dat_o = ram_dout_i;
    busy_o    = lock_active | (|pipe_vld);
  end

endmodule
